// File: rtl/fpu_vector_checker_if.sv
// Vector bus between a stimulus source and fpu_vector_checker: operands,
// opcode, rounding mode and expected result with a valid/ready handshake.
interface fpu_vector_checker_if #(
    parameter int unsigned WIDTH = 32
);
    logic             vec_valid;
    logic             vec_ready;
    logic [WIDTH-1:0] vec_opa;
    logic [WIDTH-1:0] vec_opb;
    logic [2:0]       vec_op;
    logic [1:0]       vec_rmode;
    logic [WIDTH-1:0] vec_exp;
    logic             vec_last;

    modport master (
        output vec_valid,
        output vec_opa,
        output vec_opb,
        output vec_op,
        output vec_rmode,
        output vec_exp,
        output vec_last,
        input  vec_ready
    );

    modport slave (
        input  vec_valid,
        input  vec_opa,
        input  vec_opb,
        input  vec_op,
        input  vec_rmode,
        input  vec_exp,
        input  vec_last,
        output vec_ready
    );
endinterface

// File: rtl/fpu_vector_checker.sv
// Streams test vectors into an FPU, compares each result LATENCY cycles later
// against the expected value and tallies pass/fail. Optional first-failure
// capture is enabled by defining FPU_CHK_FIRST_FAIL_CAPTURE_EN.
module fpu_vector_checker #(
    parameter int unsigned WIDTH   = 32,
    parameter int unsigned EXP_W   = 8,
    parameter int unsigned LATENCY = 4,
    parameter int unsigned CNT_W   = 16,
    parameter int unsigned ULP_TOL = 0
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 start,
    fpu_vector_checker_if.slave  vec,
    output logic [WIDTH-1:0]     fpu_opa,
    output logic [WIDTH-1:0]     fpu_opb,
    output logic [2:0]           fpu_op,
    output logic [1:0]           fpu_rmode,
    input  logic [WIDTH-1:0]     fpu_out,
    output logic                 busy,
    output logic                 done,
    output logic [CNT_W-1:0]     pass_cnt,
    output logic [CNT_W-1:0]     fail_cnt,
    output logic                 mismatch
`ifdef FPU_CHK_FIRST_FAIL_CAPTURE_EN
    ,
    output logic [CNT_W-1:0]     fail_idx,
    output logic [WIDTH-1:0]     fail_act,
    output logic [WIDTH-1:0]     fail_exp,
    output logic                 fail_vld
`endif
);

    localparam int unsigned DEPTH = LATENCY + 1;
    localparam int unsigned MAN_W = WIDTH - EXP_W - 1;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } state_e;

    state_e           state_q, state_d;
    logic             start_run_d;
    logic             ready_q;
    logic             busy_q;
    logic             done_q;
    logic             mismatch_q;
    logic [WIDTH-1:0] opa_q;
    logic [WIDTH-1:0] opb_q;
    logic [2:0]       op_q;
    logic [1:0]       rmode_q;
    logic [CNT_W-1:0] pass_q;
    logic [CNT_W-1:0] fail_q;
    logic [CNT_W-1:0] idx_q;

    // Tag pipeline: slot k holds the vector accepted k+1 edges ago.
    logic [DEPTH-1:0] tag_vld_q;
    logic [WIDTH-1:0] tag_exp_q [DEPTH];
    logic [CNT_W-1:0] tag_idx_q [DEPTH];

    logic             accept;
    logic             cmp_vld;
    logic [WIDTH-1:0] cmp_exp;
    logic [CNT_W-1:0] cmp_idx;
    logic             match;
    logic             ulp_ok;
    logic [WIDTH-1:0] mag_act;
    logic [WIDTH-1:0] mag_exp;
    logic [WIDTH-1:0] mag_diff;

    function automatic logic is_nan(input logic [WIDTH-1:0] v);
        return (&v[WIDTH-2 -: EXP_W]) && (|v[MAN_W-1:0]);
    endfunction

    assign accept  = vec.vec_valid & ready_q;
    assign cmp_vld = tag_vld_q[LATENCY];
    assign cmp_exp = tag_exp_q[LATENCY];
    assign cmp_idx = tag_idx_q[LATENCY];

    // Result match: exact bits, any-NaN vs any-NaN, or within ULP_TOL of same sign.
    always_comb begin
        mag_act  = {1'b0, fpu_out[WIDTH-2:0]};
        mag_exp  = {1'b0, cmp_exp[WIDTH-2:0]};
        mag_diff = (mag_act >= mag_exp) ? (mag_act - mag_exp) : (mag_exp - mag_act);
        ulp_ok   = (ULP_TOL != 32'd0) &&
                   (fpu_out[WIDTH-1] == cmp_exp[WIDTH-1]) &&
                   (mag_diff <= WIDTH'(ULP_TOL));
        match    = (fpu_out == cmp_exp) || (is_nan(fpu_out) && is_nan(cmp_exp)) || ulp_ok;
    end

    always_comb begin
        state_d     = state_q;
        start_run_d = 1'b0;
        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d     = RUN;
                    start_run_d = 1'b1;
                end
            end
            RUN: begin
                if (accept && vec.vec_last) begin
                    state_d = DRAIN;
                end
            end
            DRAIN: begin
                if (~|tag_vld_q) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                if (start) begin
                    state_d     = RUN;
                    start_run_d = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            ready_q    <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            mismatch_q <= 1'b0;
            opa_q      <= '0;
            opb_q      <= '0;
            op_q       <= '0;
            rmode_q    <= '0;
            pass_q     <= '0;
            fail_q     <= '0;
            idx_q      <= '0;
            tag_vld_q  <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                tag_exp_q[i] <= '0;
                tag_idx_q[i] <= '0;
            end
        end else begin
            state_q    <= state_d;
            ready_q    <= (state_d == RUN);
            busy_q     <= (state_d == RUN) || (state_d == DRAIN);
            done_q     <= (state_d == DONE);
            mismatch_q <= cmp_vld && !match;

            if (accept) begin
                opa_q   <= vec.vec_opa;
                opb_q   <= vec.vec_opb;
                op_q    <= vec.vec_op;
                rmode_q <= vec.vec_rmode;
            end

            tag_vld_q    <= {tag_vld_q[DEPTH-2:0], accept};
            tag_exp_q[0] <= vec.vec_exp;
            tag_idx_q[0] <= idx_q;
            for (int i = 1; i < DEPTH; i++) begin
                tag_exp_q[i] <= tag_exp_q[i-1];
                tag_idx_q[i] <= tag_idx_q[i-1];
            end

            if (start_run_d) begin
                pass_q <= '0;
                fail_q <= '0;
                idx_q  <= '0;
            end else begin
                if (accept) begin
                    idx_q <= idx_q + CNT_W'(1);
                end
                // Tallies saturate at all-ones.
                if (cmp_vld && match && !(&pass_q)) begin
                    pass_q <= pass_q + CNT_W'(1);
                end
                if (cmp_vld && !match && !(&fail_q)) begin
                    fail_q <= fail_q + CNT_W'(1);
                end
            end
        end
    end

`ifdef FPU_CHK_FIRST_FAIL_CAPTURE_EN
    logic             fail_vld_q;
    logic [CNT_W-1:0] fail_idx_q;
    logic [WIDTH-1:0] fail_act_q;
    logic [WIDTH-1:0] fail_exp_q;

    // Latch only the first failing compare of a run.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fail_vld_q <= 1'b0;
            fail_idx_q <= '0;
            fail_act_q <= '0;
            fail_exp_q <= '0;
        end else if (start_run_d) begin
            fail_vld_q <= 1'b0;
            fail_idx_q <= '0;
            fail_act_q <= '0;
            fail_exp_q <= '0;
        end else if (cmp_vld && !match && !fail_vld_q) begin
            fail_vld_q <= 1'b1;
            fail_idx_q <= cmp_idx;
            fail_act_q <= fpu_out;
            fail_exp_q <= cmp_exp;
        end
    end

    assign fail_vld = fail_vld_q;
    assign fail_idx = fail_idx_q;
    assign fail_act = fail_act_q;
    assign fail_exp = fail_exp_q;
`else
    logic unused_cmp_idx;
    assign unused_cmp_idx = ^cmp_idx;
`endif

    assign vec.vec_ready = ready_q;
    assign fpu_opa       = opa_q;
    assign fpu_opb       = opb_q;
    assign fpu_op        = op_q;
    assign fpu_rmode     = rmode_q;
    assign busy          = busy_q;
    assign done          = done_q;
    assign pass_cnt      = pass_q;
    assign fail_cnt      = fail_q;
    assign mismatch      = mismatch_q;

endmodule

// File: tb/tb_fpu_vector_checker.sv
// Directed bench: two checkers (A: defaults, B: ULP_TOL=1, CNT_W=4) share one
// stimulus stream; each sees its own behavioural FPU stand-in.
module tb_fpu_vector_checker;

    localparam int unsigned LAT = 4;

    logic clk;
    logic rst_n;
    logic start;
    logic        vec_valid;
    logic [31:0] vec_opa;
    logic [31:0] vec_opb;
    logic [2:0]  vec_op;
    logic [1:0]  vec_rmode;
    logic [31:0] vec_exp;
    logic        vec_last;

    logic [31:0] fpu_opa_a, fpu_opb_a, fpu_out_a;
    logic [2:0]  fpu_op_a;
    logic [1:0]  fpu_rmode_a;
    logic        busy_a, done_a, mm_a;
    logic [15:0] pass_a, fail_a;

    logic [31:0] fpu_opa_b, fpu_opb_b, fpu_out_b;
    logic [2:0]  fpu_op_b;
    logic [1:0]  fpu_rmode_b;
    logic        busy_b, done_b, mm_b;
    logic [3:0]  pass_b, fail_b;

`ifdef FPU_CHK_FIRST_FAIL_CAPTURE_EN
    logic [15:0] fail_idx_a;
    logic [31:0] fail_act_a, fail_exp_a;
    logic        fail_vld_a;
    logic [3:0]  fail_idx_b;
    logic [31:0] fail_act_b, fail_exp_b;
    logic        fail_vld_b;
`endif

    int n_cmp  = 0;
    int n_fail = 0;
    int mm_cnt_a = 0;
    int mm_cnt_b = 0;

    fpu_vector_checker_if #(.WIDTH(32)) vif_a ();
    fpu_vector_checker_if #(.WIDTH(32)) vif_b ();

    assign vif_a.vec_valid = vec_valid;
    assign vif_a.vec_opa   = vec_opa;
    assign vif_a.vec_opb   = vec_opb;
    assign vif_a.vec_op    = vec_op;
    assign vif_a.vec_rmode = vec_rmode;
    assign vif_a.vec_exp   = vec_exp;
    assign vif_a.vec_last  = vec_last;
    assign vif_b.vec_valid = vec_valid;
    assign vif_b.vec_opa   = vec_opa;
    assign vif_b.vec_opb   = vec_opb;
    assign vif_b.vec_op    = vec_op;
    assign vif_b.vec_rmode = vec_rmode;
    assign vif_b.vec_exp   = vec_exp;
    assign vif_b.vec_last  = vec_last;

    fpu_vector_checker #(.WIDTH(32), .EXP_W(8), .LATENCY(LAT), .CNT_W(16), .ULP_TOL(0)) dut_a (
        .clk(clk), .rst_n(rst_n), .start(start), .vec(vif_a.slave),
        .fpu_opa(fpu_opa_a), .fpu_opb(fpu_opb_a), .fpu_op(fpu_op_a), .fpu_rmode(fpu_rmode_a),
        .fpu_out(fpu_out_a), .busy(busy_a), .done(done_a),
        .pass_cnt(pass_a), .fail_cnt(fail_a), .mismatch(mm_a)
`ifdef FPU_CHK_FIRST_FAIL_CAPTURE_EN
        , .fail_idx(fail_idx_a), .fail_act(fail_act_a), .fail_exp(fail_exp_a), .fail_vld(fail_vld_a)
`endif
    );

    fpu_vector_checker #(.WIDTH(32), .EXP_W(8), .LATENCY(LAT), .CNT_W(4), .ULP_TOL(1)) dut_b (
        .clk(clk), .rst_n(rst_n), .start(start), .vec(vif_b.slave),
        .fpu_opa(fpu_opa_b), .fpu_opb(fpu_opb_b), .fpu_op(fpu_op_b), .fpu_rmode(fpu_rmode_b),
        .fpu_out(fpu_out_b), .busy(busy_b), .done(done_b),
        .pass_cnt(pass_b), .fail_cnt(fail_b), .mismatch(mm_b)
`ifdef FPU_CHK_FIRST_FAIL_CAPTURE_EN
        , .fail_idx(fail_idx_b), .fail_act(fail_act_b), .fail_exp(fail_exp_b), .fail_vld(fail_vld_b)
`endif
    );

    // FPU stand-in: 24.0 + 4.0 = 28.0 for op 0, otherwise opa passes through.
    function automatic logic [31:0] fake_fpu(input logic [31:0] a, input logic [31:0] b,
                                             input logic [2:0] op, input logic [1:0] rm);
        if (op == 3'd0 && a == 32'h41C0_0000 && b == 32'h4080_0000 && rm == 2'd2)
            return 32'h41E0_0000;
        return a;
    endfunction

    logic [31:0] pipe_a [LAT];
    logic [31:0] pipe_b [LAT];

    always @(posedge clk) begin
        pipe_a[0] <= fake_fpu(fpu_opa_a, fpu_opb_a, fpu_op_a, fpu_rmode_a);
        pipe_b[0] <= fake_fpu(fpu_opa_b, fpu_opb_b, fpu_op_b, fpu_rmode_b);
        for (int i = 1; i < LAT; i++) begin
            pipe_a[i] <= pipe_a[i-1];
            pipe_b[i] <= pipe_b[i-1];
        end
    end
    assign fpu_out_a = pipe_a[LAT-1];
    assign fpu_out_b = pipe_b[LAT-1];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (mm_a) mm_cnt_a++;
        if (mm_b) mm_cnt_b++;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_cmp++;
        assert (obs === expv) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
        end
    endtask

    task automatic wait_n(input int n);
        for (int i = 0; i < n; i++) @(negedge clk);
    endtask

    task automatic begin_run();
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic drive(input logic [31:0] a, input logic [31:0] b, input logic [2:0] op,
                         input logic [1:0] rm, input logic [31:0] e, input logic last);
        vec_valid = 1'b1;
        vec_opa   = a;
        vec_opb   = b;
        vec_op    = op;
        vec_rmode = rm;
        vec_exp   = e;
        vec_last  = last;
        @(negedge clk);
        vec_valid = 1'b0;
        vec_last  = 1'b0;
    endtask

    task automatic wait_done(input string tag);
        for (int i = 0; i < 100 && !(done_a && done_b); i++) @(negedge clk);
        chk(tag, 32'({done_a, done_b}), 32'h3);
    endtask

    logic [31:0] s4_act [5] = '{32'h7FC0_0000, 32'h7F80_0000, 32'h3F80_0002, 32'h3F80_0000, 32'hBF80_0000};
    logic [31:0] s4_exp [5] = '{32'h7FC0_0001, 32'h7FC0_0000, 32'h3F80_0000, 32'h3F80_0001, 32'h3F80_0000};

    initial begin
        int mm0_a, mm0_b, drops;
        logic [31:0] v;
        rst_n = 1'b0; start = 1'b0; vec_valid = 1'b0; vec_last = 1'b0;
        vec_opa = '0; vec_opb = '0; vec_op = '0; vec_rmode = '0; vec_exp = '0;
        wait_n(2);
        chk("rst_ready", 32'(vif_a.vec_ready), 32'd0);
        chk("rst_busy_done", 32'({busy_a, done_a, busy_b, done_b}), 32'd0);
        chk("rst_counts", 32'({pass_a, fail_a}), 32'd0);
        chk("rst_fpu_opa", fpu_opa_a, 32'd0);
        rst_n = 1'b1;
        wait_n(1);

        // Scenario 1: single matching add, exact compare and done timing.
        begin_run();
        chk("s1_ready_run", 32'(vif_a.vec_ready), 32'd1);
        chk("s1_busy_run", 32'(busy_a), 32'd1);
        drive(32'h41C0_0000, 32'h4080_0000, 3'd0, 2'd2, 32'h41E0_0000, 1'b1);
        chk("s1_fpu_opa", fpu_opa_a, 32'h41C0_0000);
        chk("s1_fpu_rmode", 32'(fpu_rmode_a), 32'd2);
        chk("s1_ready_drain", 32'(vif_a.vec_ready), 32'd0);
        chk("s1_busy_drain", 32'(busy_a), 32'd1);
        wait_n(LAT);
        chk("s1_pass_early", 32'(pass_a), 32'd0);
        wait_n(1);
        chk("s1_pass_a", 32'(pass_a), 32'd1);
        chk("s1_done_early", 32'(done_a), 32'd0);
        wait_n(1);
        chk("s1_done", 32'(done_a), 32'd1);
        chk("s1_busy_done", 32'(busy_a), 32'd0);
        chk("s1_fail_a", 32'(fail_a), 32'd0);
        chk("s1_pass_b", 32'(pass_b), 32'd1);

        // Scenario 2: expected off by one ULP.
        mm0_a = mm_cnt_a; mm0_b = mm_cnt_b;
        begin_run();
        chk("s2_clear", 32'(pass_a), 32'd0);
        chk("s2_done_clr", 32'(done_a), 32'd0);
        drive(32'h41C0_0000, 32'h4080_0000, 3'd0, 2'd2, 32'h41E0_0001, 1'b1);
        wait_done("s2_done");
        chk("s2_fail_a", 32'(fail_a), 32'd1);
        chk("s2_pass_a", 32'(pass_a), 32'd0);
        chk("s2_mm_a", 32'(mm_cnt_a - mm0_a), 32'd1);
        chk("s2_pass_b", 32'(pass_b), 32'd1);
        chk("s2_fail_b", 32'(fail_b), 32'd0);
        chk("s2_mm_b", 32'(mm_cnt_b - mm0_b), 32'd0);
`ifdef FPU_CHK_FIRST_FAIL_CAPTURE_EN
        chk("s2_fail_vld", 32'(fail_vld_a), 32'd1);
        chk("s2_fail_idx", 32'(fail_idx_a), 32'd0);
        chk("s2_fail_act", fail_act_a, 32'h41E0_0000);
        chk("s2_fail_exp", fail_exp_a, 32'h41E0_0001);
`endif

        // Scenario 3: 20 back-to-back vectors, the 7th (index 6) wrong.
        drops = 0;
        begin_run();
        for (int i = 0; i < 20; i++) begin
            if (!vif_a.vec_ready) drops++;
            v = 32'h3F80_0000 + 32'(i);
            drive(v, 32'd0, 3'd7, 2'd0, (i == 6) ? v + 32'h100 : v, i == 19);
        end
        wait_done("s3_done");
        chk("s3_ready_drops", 32'(drops), 32'd0);
        chk("s3_pass_a", 32'(pass_a), 32'd19);
        chk("s3_fail_a", 32'(fail_a), 32'd1);
        chk("s3_pass_b_sat", 32'(pass_b), 32'd15);
        chk("s3_fail_b", 32'(fail_b), 32'd1);
`ifdef FPU_CHK_FIRST_FAIL_CAPTURE_EN
        chk("s3_fail_idx_a", 32'(fail_idx_a), 32'd6);
        chk("s3_fail_idx_b", 32'(fail_idx_b), 32'd6);
`endif

        // Scenario 4: NaN equivalence, inf vs NaN, ULP boundary, sign.
        begin_run();
        for (int i = 0; i < 5; i++) begin
            drive(s4_act[i], 32'd0, 3'd7, 2'd1, s4_exp[i], i == 4);
        end
        wait_done("s4_done");
        chk("s4_pass_a", 32'(pass_a), 32'd1);
        chk("s4_fail_a", 32'(fail_a), 32'd4);
        chk("s4_pass_b", 32'(pass_b), 32'd2);
        chk("s4_fail_b", 32'(fail_b), 32'd3);
`ifdef FPU_CHK_FIRST_FAIL_CAPTURE_EN
        chk("s4_fail_idx", 32'(fail_idx_a), 32'd1);
        chk("s4_fail_act", fail_act_a, 32'h7F80_0000);
        chk("s4_fail_exp", fail_exp_a, 32'h7FC0_0000);
`endif

        // Scenario 5: reset in DRAIN with three compares in flight.
        begin_run();
        for (int i = 0; i < 3; i++) begin
            drive(32'h100 + 32'(i), 32'd0, 3'd7, 2'd0, 32'h0, i == 2);
        end
        wait_n(1);
        chk("s5_busy_drain", 32'(busy_a), 32'd1);
        mm0_a = mm_cnt_a;
        rst_n = 1'b0;
        #1;
        chk("s5_rst_status", 32'({vif_a.vec_ready, busy_a, done_a, mm_a, busy_b, done_b, mm_b}), 32'd0);
        chk("s5_rst_counts", 32'({pass_a, fail_a, pass_b, fail_b}), 32'd0);
        chk("s5_rst_fpu", fpu_opa_a, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        wait_n(10);
        chk("s5_no_count", 32'({pass_a, fail_a, pass_b, fail_b}), 32'd0);
        chk("s5_no_mm", 32'(mm_cnt_a - mm0_a), 32'd0);
        chk("s5_idle", 32'({busy_a, done_a}), 32'd0);
        begin_run();
        drive(32'h41C0_0000, 32'h4080_0000, 3'd0, 2'd2, 32'h41E0_0000, 1'b1);
        wait_done("s5_fresh_done");
        chk("s5_fresh_pass", 32'(pass_a), 32'd1);

        // Scenario 6: 20 failures saturate the 4-bit fail counter.
        mm0_a = mm_cnt_a; mm0_b = mm_cnt_b;
        begin_run();
        for (int i = 0; i < 20; i++) begin
            v = 32'h4000_0000 + 32'(i);
            drive(v, 32'd0, 3'd7, 2'd0, v + 32'h1000, i == 19);
        end
        wait_done("s6_done");
        chk("s6_fail_b_sat", 32'(fail_b), 32'd15);
        chk("s6_mm_b", 32'(mm_cnt_b - mm0_b), 32'd20);
        chk("s6_fail_a", 32'(fail_a), 32'd20);
        chk("s6_mm_a", 32'(mm_cnt_a - mm0_a), 32'd20);
        chk("s6_pass_b", 32'(pass_b), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/fpu_vector_checker.md
FPU_VECTOR_CHECKER -- requirements
Module: fpu_vector_checker

Interface
REQ-001 Parameter WIDTH, default 32: operand/result width.
REQ-002 Parameter EXP_W, default 8: exponent field width, used for NaN detection.
REQ-003 Parameter LATENCY, default 4: FPU cycles from operand change to result valid; legal range 1..16.
REQ-004 Parameter CNT_W, default 16: width of the pass/fail/index counters.
REQ-005 Parameter ULP_TOL, default 0: permitted magnitude difference, in ULPs, for a match.
REQ-006 Port clk, input, 1: single clock, rising edge.
REQ-007 Port rst_n, input, 1: asynchronous active-low reset.
REQ-008 Port start, input, 1: begin a run.
REQ-009 Ports vec_valid (input, 1) and vec_ready (output, 1): vector handshake.
REQ-010 Ports vec_opa and vec_opb, input, WIDTH: operands.
REQ-011 Port vec_op, input, 3: FPU operation code.
REQ-012 Port vec_rmode, input, 2: FPU rounding mode.
REQ-013 Port vec_exp, input, WIDTH: expected result.
REQ-014 Port vec_last, input, 1: marks the final vector of the run.
REQ-015 Ports fpu_opa/fpu_opb (output, WIDTH), fpu_op (output, 3), fpu_rmode (output, 2): drive the FPU.
REQ-016 Port fpu_out, input, WIDTH: FPU result.
REQ-017 Ports busy and done, output, 1: run status.
REQ-018 Ports pass_cnt and fail_cnt, output, CNT_W: comparison tallies.
REQ-019 Port mismatch, output, 1: one-cycle pulse on each failed comparison.

Function
REQ-020 The FSM SHALL have exactly four states: IDLE, RUN, DRAIN, DONE.
REQ-021 IDLE->RUN on start; on entry, pass_cnt, fail_cnt, the vector index and the capture registers SHALL clear.
REQ-022 In RUN, vec_ready=1; elsewhere vec_ready=0; start SHALL be ignored in RUN and DRAIN.
REQ-023 An accepted vector (vec_valid&vec_ready at edge N) SHALL appear on fpu_* after edge N; fpu_* hold their value when no vector is accepted.
REQ-024 The accepted expected value SHALL be tagged valid in a LATENCY+1-deep shift pipeline; fpu_out SHALL be compared at edge N+1+LATENCY.
REQ-025 Back-to-back vectors SHALL be accepted every cycle with no bubbles.
REQ-026 Acceptance with vec_last=1 SHALL move RUN->DRAIN.
REQ-027 DRAIN->DONE SHALL occur in the cycle after the last tagged compare completes.
REQ-028 DONE SHALL hold done=1 until start, which SHALL go to RUN as in REQ-021.
REQ-029 busy=1 in RUN and DRAIN.
REQ-030 Match rule: bits equal; or both values NaN (exponent all-ones, mantissa nonzero); or ULP_TOL>0, signs equal, and |act[WIDTH-2:0]-exp[WIDTH-2:0]| <= ULP_TOL, computed unsigned in WIDTH bits.
REQ-031 pass_cnt and fail_cnt SHALL saturate at all-ones; a failure SHALL assert mismatch for one cycle.
REQ-032 The vector index SHALL increment per accepted vector, wrap modulo 2^CNT_W, and travel with its pipeline tag.

Reset
REQ-033 rst_n low SHALL asynchronously force: IDLE; pipeline tags cleared; vec_ready, busy, done and mismatch =0; counters =0; fpu_* =0; capture registers =0.
REQ-034 Reset mid-run SHALL discard in-flight compares; no count SHALL change after deassertion until new vectors are accepted.

Configuration
REQ-035 Macro FPU_CHK_FIRST_FAIL_CAPTURE_EN SHALL control capture of the first failure.
REQ-036 With the macro defined, outputs fail_idx (CNT_W), fail_act (WIDTH), fail_exp (WIDTH) and fail_vld (1) SHALL latch on the first failure of a run and hold until the next run starts or reset.
REQ-037 Without the macro, those ports and their registers SHALL be absent; all other behaviour SHALL be unchanged.

Verification
REQ-038 Scenario 1: op=0, rmode=2, opa=0x41C00000 (24.0), opb=0x40800000 (4.0), exp=0x41E00000, last=1 -> pass_cnt=1, fail_cnt=0, done at edge N+2+LATENCY.
REQ-039 Scenario 2: same vector with exp=0x41E00001 and ULP_TOL=0 -> fail_cnt=1, one mismatch pulse, fail_idx=0 and fail_act=0x41E00000 (macro on); with ULP_TOL=1 -> pass_cnt=1.
REQ-040 Scenario 3: 20 back-to-back vectors, the 7th wrong -> pass_cnt=19, fail_cnt=1, fail_idx=6, vec_ready never drops before vec_last.
REQ-041 Scenario 4: fpu_out=0x7FC00000 with exp=0x7FC00001 -> counted as pass; fpu_out=0x7F800000 (inf) with exp=0x7FC00000 -> counted as fail.
REQ-042 Scenario 5: rst_n pulsed low in DRAIN with 3 vectors in flight -> all outputs zero immediately; no count change afterwards; a fresh start runs normally.
REQ-043 Scenario 6: CNT_W=4, 20 failing vectors -> fail_cnt saturates at 15, mismatch pulses 20 times.
